// File: rtl/timeout_arbiter.sv
// timeout_arbiter: a single timeout counter that NREQ requesters share.
// Ownership is granted round-robin. The owner's terminal count is captured
// at grant time. The counter advances on each qualified tick. When the
// counter reaches the terminal count, the owner gets a one-cycle expired
// pulse. The owner can give up the counter at any time by asserting cancel
// or by dropping req.
module timeout_arbiter #(
  parameter int NREQ    = 2,
  parameter int bitSize = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*bitSize-1:0] limit_in,
  input  logic [NREQ-1:0]         cancel,
  input  logic                    tick,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         expired,
  output logic                    busy,
  output logic [bitSize-1:0]      count
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // The declaration initialisers are the power-up state. They match the
  // values that reset forces.
  state_t             state      = IDLE;
  logic [IDX_W-1:0]   owner      = '0;
  logic [IDX_W-1:0]   last_owner = LAST_IDX;
  logic [bitSize-1:0] limit_q    = '0;
  logic [bitSize-1:0] count_q    = '0;
  logic [NREQ-1:0]    grant_q    = '0;
  logic [NREQ-1:0]    expired_q  = '0;

  logic [bitSize-1:0] limit_arr [NREQ];
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;

  // Split the flat limit bus into one slice per requester.
  for (genvar i = 0; i < NREQ; i++) begin : g_limit
    assign limit_arr[i] = limit_in[i*bitSize +: bitSize];
  end

  // Round-robin pick. The search starts at the requester after last_owner.
  // It scans downwards so that the nearest requester wins.
  always_comb begin
    // NOTE: each variable gets a default before the loop. Otherwise a path
    // that leaves it unassigned would infer a latch.
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_owner) + k) % NREQ);
      if (req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Main FSM. The counter and all outputs are registered in this block.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments. Every branch then
    // reads the values from before the edge, which keeps simulation order
    // independent.
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_IDX;
      limit_q    <= '0;
      count_q    <= '0;
      grant_q    <= '0;
      expired_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          expired_q <= '0;
          if (sel_valid) begin
            owner      <= sel_idx;
            last_owner <= sel_idx;
            limit_q    <= limit_arr[sel_idx];
            count_q    <= '0;
            grant_q    <= ONE_HOT0 << sel_idx;
            state      <= RUN;
          end
        end
        RUN: begin
          // An abort outranks a terminal-count tick in the same cycle.
          if (cancel[owner] || !req[owner]) begin
            grant_q <= '0;
            state   <= IDLE;
          end else if (tick) begin
            if (count_q == limit_q) begin
              grant_q   <= '0;
              expired_q <= ONE_HOT0 << owner;
              state     <= DONE;
            end else begin
              count_q <= count_q + bitSize'(1);
            end
          end
        end
        DONE: begin
          expired_q <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign expired = expired_q;
  assign busy    = (state != IDLE);
  assign count   = count_q;

endmodule

// File: tb/tb_timeout_arbiter.sv
// tb_timeout_arbiter: scenario-driven bench for timeout_arbiter with
// NREQ=2 and bitSize=16. Each scenario fills a stimulus queue and an
// expectation queue in step. It then plays one stimulus entry per clock and
// compares the outputs after the edge with the matching expectation.
module tb_timeout_arbiter;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic [1:0]  req      = '0;
  logic [31:0] limit_in = '0;
  logic [1:0]  cancel   = '0;
  logic        tick     = 1'b0;
  logic [1:0]  grant;
  logic [1:0]  expired;
  logic        busy;
  logic [15:0] count;

  int checks   = 0;
  int failures = 0;

  timeout_arbiter #(.NREQ(2), .bitSize(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .limit_in (limit_in),
    .cancel   (cancel),
    .tick     (tick),
    .grant    (grant),
    .expired  (expired),
    .busy     (busy),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Observation word: {grant, expired, busy, count}
  logic [20:0] obs;
  assign obs = {grant, expired, busy, count};

  localparam logic [20:0] MASK_ALL  = 21'h1FFFFF;
  localparam logic [20:0] MASK_CTRL = 21'h1F0000;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  cancel;
    logic        tick;
    logic [31:0] limit;
  } stim_t;

  typedef struct {
    logic [20:0] val;
    logic [20:0] mask;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  // Queue one cycle of stimulus, together with the outputs expected after
  // the next edge.
  task automatic push(input logic rst, input logic [1:0] r, input logic [1:0] c,
                      input logic t, input logic [15:0] l0, input logic [15:0] l1,
                      input logic [1:0] g, input logic [1:0] e, input logic b,
                      input logic [15:0] cnt, input logic chk_cnt);
    stim_t s;
    exp_t  x;
    s.rst = rst; s.req = r; s.cancel = c; s.tick = t; s.limit = {l1, l0};
    x.val  = {g, e, b, cnt};
    x.mask = chk_cnt ? MASK_ALL : MASK_CTRL;
    stim_q.push_back(s);
    exp_q.push_back(x);
  endtask

  task automatic apply(input stim_t s);
    reset = s.rst; req = s.req; cancel = s.cancel; tick = s.tick; limit_in = s.limit;
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t  x;
    int    cyc;
    #1;
    checks++;
    if (obs !== 21'h0) begin
      failures++;
      $display("FAIL power_up got=%h want=%h", obs, 21'h0);
    end
    // Reset overrides active requests and ticks.
    push(1, 2'b11, 2'b00, 1, 16'd0, 16'd0, 2'b00, 2'b00, 0, 16'd0, 1);
    push(1, 2'b11, 2'b00, 1, 16'd0, 16'd0, 2'b00, 2'b00, 0, 16'd0, 1);
    cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(posedge clk); #1;
      x = exp_q.pop_front(); checks++; cyc++;
      if ((obs & x.mask) !== (x.val & x.mask)) begin
        failures++;
        $display("FAIL reset cyc%0d got=%h want=%h", cyc, obs & x.mask, x.val & x.mask);
      end
    end
  endtask

  task automatic test_basic();
    stim_t s;
    exp_t  x;
    int    cyc;
    push(0, 2'b01, 2'b00, 1, 16'd3, 16'd0, 2'b01, 2'b00, 1, 16'd0, 1);
    push(0, 2'b01, 2'b00, 1, 16'd3, 16'd0, 2'b01, 2'b00, 1, 16'd1, 1);
    push(0, 2'b01, 2'b00, 1, 16'd3, 16'd0, 2'b01, 2'b00, 1, 16'd2, 1);
    push(0, 2'b01, 2'b00, 1, 16'd3, 16'd0, 2'b01, 2'b00, 1, 16'd3, 1);
    push(0, 2'b01, 2'b00, 1, 16'd3, 16'd0, 2'b00, 2'b01, 1, 16'd3, 1);
    push(0, 2'b01, 2'b00, 1, 16'd3, 16'd0, 2'b00, 2'b00, 0, 16'd0, 0);
    // The requester still holds req, so it is granted again after one IDLE cycle.
    push(0, 2'b01, 2'b00, 1, 16'd3, 16'd0, 2'b01, 2'b00, 1, 16'd0, 1);
    // Dropping req aborts the run with no expired pulse.
    push(0, 2'b00, 2'b00, 1, 16'd3, 16'd0, 2'b00, 2'b00, 0, 16'd0, 0);
    push(0, 2'b00, 2'b00, 1, 16'd3, 16'd0, 2'b00, 2'b00, 0, 16'd0, 0);
    cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(posedge clk); #1;
      x = exp_q.pop_front(); checks++; cyc++;
      if ((obs & x.mask) !== (x.val & x.mask)) begin
        failures++;
        $display("FAIL basic cyc%0d got=%h want=%h", cyc, obs & x.mask, x.val & x.mask);
      end
    end
  endtask

  task automatic test_round_robin();
    stim_t s;
    exp_t  x;
    int    cyc;
    // Reset first. Requester 0 must win even though it owned the counter last.
    push(1, 2'b11, 2'b00, 1, 16'd1, 16'd2, 2'b00, 2'b00, 0, 16'd0, 1);
    push(0, 2'b11, 2'b00, 1, 16'd1, 16'd2, 2'b01, 2'b00, 1, 16'd0, 1);
    push(0, 2'b11, 2'b00, 1, 16'd1, 16'd2, 2'b01, 2'b00, 1, 16'd1, 1);
    push(0, 2'b11, 2'b00, 1, 16'd1, 16'd2, 2'b00, 2'b01, 1, 16'd1, 1);
    push(0, 2'b11, 2'b00, 1, 16'd1, 16'd2, 2'b00, 2'b00, 0, 16'd0, 0);
    push(0, 2'b11, 2'b00, 1, 16'd1, 16'd2, 2'b10, 2'b00, 1, 16'd0, 1);
    push(0, 2'b11, 2'b00, 1, 16'd1, 16'd2, 2'b10, 2'b00, 1, 16'd1, 1);
    push(0, 2'b11, 2'b00, 1, 16'd1, 16'd2, 2'b10, 2'b00, 1, 16'd2, 1);
    push(0, 2'b11, 2'b00, 1, 16'd1, 16'd2, 2'b00, 2'b10, 1, 16'd2, 1);
    push(0, 2'b11, 2'b00, 1, 16'd1, 16'd2, 2'b00, 2'b00, 0, 16'd0, 0);
    push(0, 2'b11, 2'b00, 1, 16'd1, 16'd2, 2'b01, 2'b00, 1, 16'd0, 1);
    cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(posedge clk); #1;
      x = exp_q.pop_front(); checks++; cyc++;
      if ((obs & x.mask) !== (x.val & x.mask)) begin
        failures++;
        $display("FAIL round_robin cyc%0d got=%h want=%h", cyc, obs & x.mask, x.val & x.mask);
      end
    end
  endtask

  task automatic test_cancel();
    stim_t s;
    exp_t  x;
    int    cyc;
    push(1, 2'b00, 2'b00, 0, 16'd2, 16'd0, 2'b00, 2'b00, 0, 16'd0, 1);
    push(0, 2'b01, 2'b00, 1, 16'd2, 16'd0, 2'b01, 2'b00, 1, 16'd0, 1);
    // Changes to the non-owner's cancel and req bits are ignored.
    push(0, 2'b11, 2'b10, 1, 16'd2, 16'd0, 2'b01, 2'b00, 1, 16'd1, 1);
    push(0, 2'b01, 2'b00, 1, 16'd2, 16'd0, 2'b01, 2'b00, 1, 16'd2, 1);
    // A cancel on the terminal-count tick wins: the result is IDLE with no pulse.
    push(0, 2'b01, 2'b01, 1, 16'd2, 16'd0, 2'b00, 2'b00, 0, 16'd0, 0);
    push(0, 2'b01, 2'b00, 1, 16'd2, 16'd0, 2'b01, 2'b00, 1, 16'd0, 1);
    push(0, 2'b01, 2'b00, 0, 16'd2, 16'd0, 2'b01, 2'b00, 1, 16'd0, 1);
    cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(posedge clk); #1;
      x = exp_q.pop_front(); checks++; cyc++;
      if ((obs & x.mask) !== (x.val & x.mask)) begin
        failures++;
        $display("FAIL cancel cyc%0d got=%h want=%h", cyc, obs & x.mask, x.val & x.mask);
      end
    end
  endtask

  task automatic test_tick_gating();
    stim_t s;
    exp_t  x;
    int    cyc;
    push(1, 2'b00, 2'b00, 0, 16'd1, 16'd0, 2'b00, 2'b00, 0, 16'd0, 1);
    push(0, 2'b01, 2'b00, 0, 16'd1, 16'd0, 2'b01, 2'b00, 1, 16'd0, 1);
    // limit_in is changed to 0 after the grant. The captured limit (1) must still apply.
    push(0, 2'b01, 2'b00, 1, 16'd0, 16'd0, 2'b01, 2'b00, 1, 16'd1, 1);
    push(0, 2'b01, 2'b00, 0, 16'd0, 16'd0, 2'b01, 2'b00, 1, 16'd1, 1);
    push(0, 2'b01, 2'b00, 0, 16'd0, 16'd0, 2'b01, 2'b00, 1, 16'd1, 1);
    push(0, 2'b01, 2'b00, 1, 16'd0, 16'd0, 2'b00, 2'b01, 1, 16'd1, 1);
    push(0, 2'b00, 2'b00, 0, 16'd0, 16'd0, 2'b00, 2'b00, 0, 16'd0, 0);
    cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(posedge clk); #1;
      x = exp_q.pop_front(); checks++; cyc++;
      if ((obs & x.mask) !== (x.val & x.mask)) begin
        failures++;
        $display("FAIL tick_gating cyc%0d got=%h want=%h", cyc, obs & x.mask, x.val & x.mask);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    stim_t s;
    exp_t  x;
    int    cyc;
    push(1, 2'b00, 2'b00, 0, 16'd0, 16'd10, 2'b00, 2'b00, 0, 16'd0, 1);
    push(0, 2'b10, 2'b00, 1, 16'd0, 16'd10, 2'b10, 2'b00, 1, 16'd0, 1);
    for (int i = 1; i <= 5; i++)
      push(0, 2'b10, 2'b00, 1, 16'd0, 16'd10, 2'b10, 2'b00, 1, 16'(i), 1);
    push(1, 2'b11, 2'b00, 1, 16'd0, 16'd10, 2'b00, 2'b00, 0, 16'd0, 1);
    push(0, 2'b11, 2'b00, 1, 16'd0, 16'd10, 2'b01, 2'b00, 1, 16'd0, 1);
    // limit0 is 0, so requester 0 expires right away. This also confirms that no
    // stale pulse reaches requester 1.
    push(0, 2'b11, 2'b00, 1, 16'd0, 16'd10, 2'b00, 2'b01, 1, 16'd0, 1);
    cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(posedge clk); #1;
      x = exp_q.pop_front(); checks++; cyc++;
      if ((obs & x.mask) !== (x.val & x.mask)) begin
        failures++;
        $display("FAIL reset_mid_run cyc%0d got=%h want=%h", cyc, obs & x.mask, x.val & x.mask);
      end
    end
  endtask

  task automatic test_limit_zero();
    stim_t s;
    exp_t  x;
    int    cyc;
    push(1, 2'b00, 2'b00, 0, 16'd0, 16'd0, 2'b00, 2'b00, 0, 16'd0, 1);
    push(0, 2'b01, 2'b00, 1, 16'd0, 16'd0, 2'b01, 2'b00, 1, 16'd0, 1);
    push(0, 2'b01, 2'b00, 1, 16'd0, 16'd0, 2'b00, 2'b01, 1, 16'd0, 1);
    push(0, 2'b00, 2'b00, 1, 16'd0, 16'd0, 2'b00, 2'b00, 0, 16'd0, 1);
    push(0, 2'b00, 2'b00, 1, 16'd0, 16'd0, 2'b00, 2'b00, 0, 16'd0, 1);
    cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s);
      @(posedge clk); #1;
      x = exp_q.pop_front(); checks++; cyc++;
      if ((obs & x.mask) !== (x.val & x.mask)) begin
        failures++;
        $display("FAIL limit_zero cyc%0d got=%h want=%h", cyc, obs & x.mask, x.val & x.mask);
      end
    end
  endtask

  // Invariant: grant and expired are each at most one-hot and never high together.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ((grant & (grant - 2'd1)) != 2'd0 || (expired & (expired - 2'd1)) != 2'd0 ||
          (grant != 2'd0 && expired != 2'd0)) begin
        failures++;
        $display("FAIL onehot got grant=%b expired=%b want exclusive one-hot", grant, expired);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_cancel();
    test_tick_gating();
    test_reset_mid_run();
    test_limit_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
